// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width and receiver/transmitter state encoding.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_WAIT  = 3'd4
  } uart_state_t;

endpackage : uart_pkg

// File: rtl/rx_baud_tick.sv
// Free-running oversample tick generator: one-clock tick every DIV clocks.
module rx_baud_tick #(
  parameter int system_clock = 25000000,
  parameter int rx_baudrate  = 9600,
  parameter int oversample   = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV_RAW = system_clock / (rx_baudrate * oversample);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: wrap at DIV-1, never pauses.
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule : rx_baud_tick

// File: rtl/uart_rx_top.sv
// UART 8N1 receiver: synchronizer, 3-sample majority voter, frame FSM and output registers.
module uart_rx_top
  import uart_pkg::*;
#(
  parameter int system_clock   = 25000000,
  parameter int rx_baudrate    = 9600,
  parameter int oversample     = 16,
  parameter int stop_bit_count = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_input,
  output logic [7:0] rx_output,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       rx_frame_error
);

  localparam int TW = (oversample > 1) ? $clog2(oversample) : 1;
  localparam logic [TW-1:0] MID_TICK  = TW'(oversample / 2 + 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(oversample - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (stop_bit_count == 2) ? 1'b1 : 1'b0;

  logic tick;

  rx_baud_tick #(
    .system_clock(system_clock),
    .rx_baudrate (rx_baudrate),
    .oversample  (oversample)
  ) u_baud_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  logic       sync1_q, sync2_q;
  logic [2:0] samp_q;
  logic       vote;

  // Two-flop synchronizer (idle-high reset) and tick-sampled history of the synced line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      samp_q  <= 3'b111;
    end else begin
      sync1_q <= rx_input;
      sync2_q <= sync1_q;
      if (tick) samp_q <= {samp_q[1:0], sync2_q};
    end
  end

  // Majority of the two previous tick samples and the one being taken on this tick.
  assign vote = (samp_q[1] & samp_q[0]) | (samp_q[1] & sync2_q) | (samp_q[0] & sync2_q);

  uart_state_t   state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d, tick_cnt_inc;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          stop_cnt_q, stop_cnt_d;
  logic          stop_err_q, stop_err_d, stop_err_now;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_output_q, rx_output_d;
  logic          rx_done_q, rx_done_d;
  logic          rx_busy_q, rx_busy_d;
  logic          rx_frame_error_q, rx_frame_error_d;

  assign tick_cnt_inc = (tick_cnt_q == LAST_TICK) ? '0 : tick_cnt_q + TW'(1);
  assign stop_err_now = stop_err_q | ~vote;

  // Frame FSM next-state: the tick counter wraps once per bit, so every bit is voted at MID_TICK.
  always_comb begin
    state_d          = state_q;
    tick_cnt_d       = tick_cnt_q;
    bit_cnt_d        = bit_cnt_q;
    stop_cnt_d       = stop_cnt_q;
    stop_err_d       = stop_err_q;
    shift_d          = shift_q;
    rx_output_d      = rx_output_q;
    rx_done_d        = 1'b0;
    rx_frame_error_d = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!sync2_q) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
          end
        end
        ST_START: begin
          tick_cnt_d = tick_cnt_inc;
          if (tick_cnt_q == MID_TICK) begin
            if (!vote) begin
              state_d   = ST_DATA;
              bit_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          tick_cnt_d = tick_cnt_inc;
          if (tick_cnt_q == MID_TICK) begin
            shift_d = {vote, shift_q[7:1]};
            if (bit_cnt_q == LAST_BIT) begin
              state_d    = ST_STOP;
              stop_cnt_d = 1'b0;
              stop_err_d = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        ST_STOP: begin
          tick_cnt_d = tick_cnt_inc;
          if (tick_cnt_q == MID_TICK) begin
            if (stop_cnt_q == STOP_LAST) begin
              if (stop_err_now) begin
                rx_frame_error_d = 1'b1;
                state_d          = ST_WAIT;
              end else begin
                rx_output_d = shift_q;
                rx_done_d   = 1'b1;
                state_d     = ST_IDLE;
              end
            end else begin
              stop_cnt_d = 1'b1;
              stop_err_d = stop_err_now;
            end
          end
        end
        ST_WAIT: begin
          if (sync2_q) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    rx_busy_d = (state_d != ST_IDLE);
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      tick_cnt_q       <= '0;
      bit_cnt_q        <= '0;
      stop_cnt_q       <= 1'b0;
      stop_err_q       <= 1'b0;
      shift_q          <= '0;
      rx_output_q      <= 8'h00;
      rx_done_q        <= 1'b0;
      rx_busy_q        <= 1'b0;
      rx_frame_error_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      tick_cnt_q       <= tick_cnt_d;
      bit_cnt_q        <= bit_cnt_d;
      stop_cnt_q       <= stop_cnt_d;
      stop_err_q       <= stop_err_d;
      shift_q          <= shift_d;
      rx_output_q      <= rx_output_d;
      rx_done_q        <= rx_done_d;
      rx_busy_q        <= rx_busy_d;
      rx_frame_error_q <= rx_frame_error_d;
    end
  end

  assign rx_output      = rx_output_q;
  assign rx_done        = rx_done_q;
  assign rx_busy        = rx_busy_q;
  assign rx_frame_error = rx_frame_error_q;

endmodule : uart_rx_top

// File: tb/tb_uart_rx_top.sv
// Bench for uart_rx_top: serial frames in, received bytes compared to the bytes sent.
module tb_uart_rx_top;

  localparam int SYS  = 1536000;
  localparam int BAUD = 9600;
  localparam int OS   = 16;
  localparam int BIT  = 160;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_input = 1'b1;
  logic [7:0] rx_output;
  logic       rx_done;
  logic       rx_busy;
  logic       rx_frame_error;

  uart_rx_top #(
    .system_clock  (SYS),
    .rx_baudrate   (BAUD),
    .oversample    (OS),
    .stop_bit_count(1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_input      (rx_input),
    .rx_output     (rx_output),
    .rx_done       (rx_done),
    .rx_busy       (rx_busy),
    .rx_frame_error(rx_frame_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int busy_cyc = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // Observe strobes on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rx_done) got_q.push_back(rx_output);
    if (rx_frame_error) fe_cnt++;
    if (rx_done && rx_frame_error) both_cnt++;
    if (rx_busy) busy_cyc++;
  end

  task automatic hold(input logic v, input int n);
    rx_input = v;
    repeat (n) @(posedge clk);
  endtask

  // Reference: a frame with a good stop bit must yield exactly its byte.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int jit);
    int   off[11];
    logic lv[10];
    off[0]  = 0;
    off[10] = 0;
    for (int k = 1; k < 10; k++)
      off[k] = (jit > 0) ? int'($urandom_range(0, 2 * jit)) - jit : 0;
    lv[0] = 1'b0;
    for (int i = 0; i < 8; i++) lv[i + 1] = b[i];
    lv[9] = stop_ok;
    for (int k = 0; k < 10; k++) hold(lv[k], BIT + off[k + 1] - off[k]);
    if (stop_ok) exp_q.push_back(b);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx_input = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (rx_output !== 8'h00) begin errors++; $display("FAIL reset_output: got %h expected 00", rx_output); end
    checks++; if (rx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", rx_done); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    checks++; if (rx_frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", rx_frame_error); end
    rst_n = 1'b1;
    got_q.delete();
    hold(1'b1, 2000);
    @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", rx_busy); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL idle_done: got %0d pulses expected 0", got_q.size()); end
    checks++; if (rx_output !== 8'h00) begin errors++; $display("FAIL idle_output: got %h expected 00", rx_output); end
    $display("reset/idle: output=%h busy=%b", rx_output, rx_busy);
  endtask

  task automatic test_single;
    int fe0;
    got_q.delete(); exp_q.delete();
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b1, 0);
    hold(1'b1, 100);
    @(negedge clk);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL single_count: got %0d pulses expected 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'h55) begin errors++; $display("FAIL single_value: got %h expected 55", got_q[0]); end
    end
    checks++; if (fe_cnt !== fe0) begin errors++; $display("FAIL single_ferr: got %0d expected %0d", fe_cnt, fe0); end
    checks++; if (rx_output !== 8'h55) begin errors++; $display("FAIL single_hold: got %h expected 55", rx_output); end
    $display("frame 55: rx_output=%h", rx_output);
  endtask

  task automatic test_back_to_back;
    got_q.delete(); exp_q.delete();
    send_frame(8'hA3, 1'b1, 0);
    send_frame(8'h0F, 1'b1, 0);
    hold(1'b1, 100);
    @(negedge clk);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_value[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    $display("back-to-back: %0d bytes received", got_q.size());
  endtask

  task automatic test_glitch;
    int fe0, busy0;
    got_q.delete();
    fe0 = fe_cnt; busy0 = busy_cyc;
    hold(1'b0, 40);
    hold(1'b1, 300);
    @(negedge clk);
    checks++; if (busy_cyc == busy0) begin errors++; $display("FAIL glitch_busy_pulse: got 0 busy cycles expected >0"); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b expected 0", rx_busy); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL glitch_done: got %0d expected 0", got_q.size()); end
    checks++; if (fe_cnt !== fe0) begin errors++; $display("FAIL glitch_ferr: got %0d expected %0d", fe_cnt, fe0); end
    $display("glitch: busy cycles=%0d", busy_cyc - busy0);
  endtask

  task automatic test_frame_error;
    int fe0;
    logic [7:0] prev;
    got_q.delete(); exp_q.delete();
    fe0 = fe_cnt;
    prev = 8'h0F;
    send_frame(8'h3C, 1'b0, 0);
    hold(1'b0, 400);
    @(negedge clk);
    checks++; if (fe_cnt !== fe0 + 1) begin errors++; $display("FAIL ferr_pulse: got %0d expected %0d", fe_cnt - fe0, 1); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL ferr_done: got %0d expected 0", got_q.size()); end
    checks++; if (rx_output !== prev) begin errors++; $display("FAIL ferr_output: got %h expected %h", rx_output, prev); end
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL ferr_wait_busy: got %b expected 1", rx_busy); end
    hold(1'b1, 200);
    @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_release: got %b expected 0", rx_busy); end
    send_frame(8'h81, 1'b1, 0);
    hold(1'b1, 100);
    @(negedge clk);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL ferr_next_count: got %0d expected 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'h81) begin errors++; $display("FAIL ferr_next_value: got %h expected 81", got_q[0]); end
    end
    $display("frame error then 81: rx_output=%h", rx_output);
  endtask

  task automatic test_reset_mid;
    got_q.delete(); exp_q.delete();
    hold(1'b0, BIT);
    hold(1'b1, 3 * BIT + 50);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (rx_output !== 8'h00) begin errors++; $display("FAIL midrst_output: got %h expected 00", rx_output); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", rx_busy); end
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    hold(1'b1, 5 * BIT);
    @(negedge clk);
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL midrst_strobe: got %0d expected 0", got_q.size()); end
    send_frame(8'h12, 1'b1, 0);
    hold(1'b1, 100);
    @(negedge clk);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL midrst_next_count: got %0d expected 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'h12) begin errors++; $display("FAIL midrst_next_value: got %h expected 12", got_q[0]); end
    end
    $display("reset mid-frame then 12: rx_output=%h", rx_output);
  endtask

  task automatic test_jitter;
    logic [7:0] b;
    got_q.delete(); exp_q.delete();
    for (int n = 0; n < 20; n++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, 3);
      hold(1'b1, int'($urandom_range(0, 40)));
    end
    hold(1'b1, 200);
    @(negedge clk);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL jitter_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL jitter_value[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      else $display("jitter byte %0d: %h", i, got_q[i]);
    end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL done_and_ferr: got %0d overlaps expected 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid();
    test_jitter();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_rx_top
